// File: rtl/phase_tag_readout_ctrl_if.sv
// Bundles the FIFO read port, host byte stream and status of the phase-tag readout controller.
// Pure wiring, no latency.
// Backpressure is carried by tx_ready; the controller is the master side.
interface phase_tag_readout_ctrl_if;
    logic        enable;
    logic        fifo_empty;
    logic [15:0] fifo_data;
    logic        fifo_rd_en;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic [15:0] tag_count;

    modport master (
        input  enable, fifo_empty, fifo_data, tx_ready,
        output fifo_rd_en, tx_data, tx_valid, busy, tag_count
    );

    modport slave (
        output enable, fifo_empty, fifo_data, tx_ready,
        input  fifo_rd_en, tx_data, tx_valid, busy, tag_count
    );
endinterface

// File: rtl/phase_tag_readout_ctrl.sv
// Phase-tag FIFO read sequencer: drains 16-bit tags and sends them MSB byte first, with sync markers.
// Latency: RD_LATENCY+3 cycles per tag with tx_ready high, plus one cycle for each sync byte.
// Backpressure: tx_ready low freezes tx_data/tx_valid; no FIFO read is issued until the current tag is sent.
module phase_tag_readout_ctrl #(
    parameter int unsigned RD_LATENCY    = 1,
    parameter int unsigned SYNC_INTERVAL = 64,
    parameter logic [7:0]  SYNC_BYTE     = 8'hA5
) (
    input logic                     clk,
    input logic                     rst_n,
    phase_tag_readout_ctrl_if.master bus
);

    localparam int unsigned SCNT_W = $clog2(SYNC_INTERVAL + 1);
    localparam logic [SCNT_W-1:0] SYNC_DUE = SCNT_W'(SYNC_INTERVAL);
    localparam logic [1:0]        LAT_LAST = 2'(RD_LATENCY);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        RD_REQ,
        RD_WAIT,
        SEND_HI,
        SEND_LO
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_valid_q, tx_valid_d;
    logic [15:0]         tag_q, tag_d;
    logic [15:0]         tag_count_q, tag_count_d;
    logic [SCNT_W-1:0]   sync_cnt_q, sync_cnt_d;
    logic [SCNT_W-1:0]   sync_cnt_inc;
    logic                first_q, first_d;
    logic [1:0]          lat_cnt_q, lat_cnt_d;
    logic                rd_en;
    logic                hs;
    logic                can_go;
    logic                sync_due;

    assign hs           = tx_valid_q & bus.tx_ready;
    assign can_go       = bus.enable & ~bus.fifo_empty;
    assign sync_due     = first_q | (sync_cnt_q == SYNC_DUE);
    assign sync_cnt_inc = sync_cnt_q + SCNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tx_data_q   <= 8'h00;
            tx_valid_q  <= 1'b0;
            tag_q       <= 16'h0000;
            tag_count_q <= 16'h0000;
            sync_cnt_q  <= '0;
            first_q     <= 1'b1;
            lat_cnt_q   <= 2'd0;
        end else begin
            state_q     <= state_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            tag_q       <= tag_d;
            tag_count_q <= tag_count_d;
            sync_cnt_q  <= sync_cnt_d;
            first_q     <= first_d;
            lat_cnt_q   <= lat_cnt_d;
        end
    end

    // tx_valid/tx_data are set up on entry to each sending state so the link sees registered outputs.
    always_comb begin
        state_d     = state_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        tag_d       = tag_q;
        tag_count_d = tag_count_q;
        sync_cnt_d  = sync_cnt_q;
        first_d     = first_q;
        lat_cnt_d   = lat_cnt_q;
        rd_en       = 1'b0;

        case (state_q)
            IDLE: begin
                if (can_go) begin
                    if (sync_due) begin
                        state_d    = SYNC;
                        tx_valid_d = 1'b1;
                        tx_data_d  = SYNC_BYTE;
                    end else begin
                        state_d = RD_REQ;
                    end
                end
            end

            SYNC: begin
                if (hs) begin
                    first_d    = 1'b0;
                    sync_cnt_d = '0;
                    tx_valid_d = 1'b0;
                    state_d    = bus.enable ? RD_REQ : IDLE;
                end
            end

            // Empty is re-checked here so a read is never issued against an empty FIFO.
            RD_REQ: begin
                if (bus.fifo_empty) begin
                    state_d = IDLE;
                end else begin
                    rd_en     = 1'b1;
                    lat_cnt_d = 2'd1;
                    state_d   = RD_WAIT;
                end
            end

            RD_WAIT: begin
                if (lat_cnt_q == LAT_LAST) begin
                    tag_d      = bus.fifo_data;
                    tx_data_d  = bus.fifo_data[15:8];
                    tx_valid_d = 1'b1;
                    state_d    = SEND_HI;
                end else begin
                    lat_cnt_d = lat_cnt_q + 2'd1;
                end
            end

            SEND_HI: begin
                if (hs) begin
                    tx_data_d = tag_q[7:0];
                    state_d   = SEND_LO;
                end
            end

            SEND_LO: begin
                if (hs) begin
                    tag_count_d = tag_count_q + 16'd1;
                    sync_cnt_d  = sync_cnt_inc;
                    tx_valid_d  = 1'b0;
                    if (can_go) begin
                        if (sync_cnt_inc == SYNC_DUE) begin
                            state_d    = SYNC;
                            tx_valid_d = 1'b1;
                            tx_data_d  = SYNC_BYTE;
                        end else begin
                            state_d = RD_REQ;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d    = IDLE;
                tx_valid_d = 1'b0;
            end
        endcase
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.tx_data    = tx_data_q;
    assign bus.tx_valid   = tx_valid_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.tag_count  = tag_count_q;

endmodule

// File: tb/tb_phase_tag_readout_ctrl.sv
// Bench for phase_tag_readout_ctrl: FIFO model with delayed Q, byte-stream scoreboard, random backpressure.
module tb_phase_tag_readout_ctrl;

    localparam int RD_LAT   = 2;
    localparam int SYNC_INT = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    phase_tag_readout_ctrl_if bus();

    phase_tag_readout_ctrl #(
        .RD_LATENCY    (RD_LAT),
        .SYNC_INTERVAL (SYNC_INT),
        .SYNC_BYTE     (8'hA5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: FIFO contents and the byte stream the link must see.
    logic [15:0] fq[$];
    logic [7:0]  exp_q[$];
    bit          model_first;
    int          model_since;
    int          pushed;

    task automatic push_tag(input logic [15:0] t);
        fq.push_back(t);
        bus.fifo_empty = 1'b0;
        if (model_first || model_since == SYNC_INT) begin
            exp_q.push_back(8'hA5);
            model_first = 1'b0;
            model_since = 0;
        end
        exp_q.push_back(t[15:8]);
        exp_q.push_back(t[7:0]);
        model_since++;
        pushed++;
    endtask

    task automatic model_clear();
        fq.delete();
        exp_q.delete();
        model_first    = 1'b1;
        model_since    = 0;
        pushed         = 0;
        bus.fifo_empty = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // FIFO read port: Q shows a popped tag RD_LAT cycles after the rd_en cycle, garbage otherwise.
    logic [15:0] pipe_dat [RD_LAT];
    bit          pipe_vld [RD_LAT];
    always begin : fifo_model
        bit take;
        @(negedge clk);
        take = rst_n && bus.fifo_rd_en && (fq.size() != 0);
        @(posedge clk);
        #1;
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) pipe_vld[i] = 1'b0;
        end else begin
            for (int i = RD_LAT - 1; i > 0; i--) begin
                pipe_vld[i] = pipe_vld[i-1];
                pipe_dat[i] = pipe_dat[i-1];
            end
            pipe_vld[0] = take;
            if (take) pipe_dat[0] = fq.pop_front();
            bus.fifo_empty = (fq.size() == 0);
        end
        bus.fifo_data = pipe_vld[RD_LAT-1] ? pipe_dat[RD_LAT-1] : 16'($urandom);
    end

    int          cyc = 0;
    int          rd_cnt;
    int          bad_rd = 0;
    int          stall_bad = 0;
    int          byte_idx;
    int          a5_seen;
    logic [7:0]  first_byte;
    int          rd_stamp[$];
    bit          prev_stall;
    logic [7:0]  prev_dat;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst_n) begin
            rd_cnt     = 0;
            byte_idx   = 0;
            a5_seen    = 0;
            prev_stall = 1'b0;
            rd_stamp.delete();
        end else begin
            if (bus.fifo_rd_en) begin
                rd_cnt++;
                rd_stamp.push_back(cyc);
                if (bus.fifo_empty) bad_rd++;
            end
            if (prev_stall && (!bus.tx_valid || bus.tx_data !== prev_dat)) stall_bad++;
            prev_stall = bus.tx_valid && !bus.tx_ready;
            prev_dat   = bus.tx_data;
            if (bus.tx_valid && bus.tx_ready) begin
                if (byte_idx == 0) first_byte = bus.tx_data;
                byte_idx++;
                if (bus.tx_data == 8'hA5) a5_seen++;
                if (exp_q.size() == 0) check("byte_expected", 32'(exp_q.size()), 32'd1);
                else check("tx_byte", bus.tx_data, exp_q.pop_front());
            end
        end
    end

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (n < budget && !(exp_q.size() == 0 && fq.size() == 0 && !bus.busy)) begin
            tick();
            n++;
        end
        check({tag, "_drained"}, 32'(n < budget), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_en"},     bus.fifo_rd_en, 0);
        check({tag, "_tx_valid"},  bus.tx_valid,   0);
        check({tag, "_tx_data"},   bus.tx_data,    0);
        check({tag, "_busy"},      bus.busy,       0);
        check({tag, "_tag_count"}, bus.tag_count,  0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int n;
        int rd_before;
        bus.enable    = 1'b0;
        bus.tx_ready  = 1'b0;
        bus.fifo_data = 16'h0000;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Single tag after reset: sync, then 12 34.
        push_tag(16'h1234);
        bus.enable   = 1'b1;
        bus.tx_ready = 1'b1;
        wait_idle(100, "t1");
        check("t1_tag_count", bus.tag_count, 1);
        check("t1_rd_cnt", rd_cnt, 1);
        check("t1_first_byte", first_byte, 8'hA5);
        repeat (10) tick();
        check("t1_no_extra_rd", rd_cnt, 1);
        check("t1_busy", bus.busy, 0);

        // 130 tags back to back: sync every 64 tags, fixed tag period.
        do_reset();
        bus.enable   = 1'b1;
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 130; i++) push_tag(16'($urandom) & 16'h7F7F);
        wait_idle(2000, "t2");
        check("t2_tag_count", bus.tag_count, 130);
        check("t2_rd_cnt", rd_cnt, 130);
        check("t2_sync_bytes", a5_seen, 3);
        check("t2_period", 32'(rd_stamp[2] - rd_stamp[1]), 32'(RD_LAT + 3));
        check("t2_period_sync", 32'(rd_stamp[64] - rd_stamp[63]), 32'(RD_LAT + 4));

        // Random backpressure, enable flicker and arrival times.
        for (int c = 0; c < 800; c++) begin
            bus.tx_ready = 1'($urandom_range(0, 1));
            bus.enable   = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 5) == 0) push_tag(16'($urandom));
            tick();
        end
        bus.enable   = 1'b1;
        bus.tx_ready = 1'b1;
        wait_idle(3000, "t3");
        check("t3_tag_count", bus.tag_count, 32'(pushed[15:0]));
        check("t3_rd_cnt", rd_cnt, pushed);
        check("t3_stall_hold", stall_bad, 0);

        // Drop enable while BE is stalled in the high-byte slot.
        push_tag(16'hBEEF);
        for (int i = 0; i < 4; i++) push_tag(16'($urandom));
        n = 0;
        while (n < 100 && !(bus.tx_valid && bus.tx_data == 8'hBE)) begin
            tick();
            n++;
        end
        bus.tx_ready = 1'b0;
        bus.enable   = 1'b0;
        check("t4_found_hi", 32'(n < 100), 32'd1);
        repeat (3) tick();
        bus.tx_ready = 1'b1;
        n = 0;
        while (n < 50 && bus.busy) begin
            tick();
            n++;
        end
        check("t4_stopped", 32'(n < 50), 32'd1);
        check("t4_fifo_left", 32'(fq.size()), 32'd4);
        check("t4_tag_count", bus.tag_count, 32'(pushed - 4));
        rd_before = rd_cnt;
        repeat (20) tick();
        check("t4_no_rd_when_off", rd_cnt, rd_before);
        check("t4_busy_off", bus.busy, 0);
        bus.enable = 1'b1;
        wait_idle(500, "t4_resume");
        check("t4_tag_count_end", bus.tag_count, 32'(pushed[15:0]));

        // Reset while the low byte is stalled.
        push_tag(16'h5A3C);
        push_tag(16'h1111);
        n = 0;
        while (n < 100 && !(bus.tx_valid && bus.tx_data == 8'h3C)) begin
            tick();
            n++;
        end
        bus.tx_ready = 1'b0;
        check("t5_found_lo", 32'(n < 100), 32'd1);
        tick();
        rst_n = 1'b0;
        model_clear();
        #1;
        check_reset_outputs("t5_mid_reset");
        repeat (2) tick();
        rst_n        = 1'b1;
        bus.tx_ready = 1'b1;
        push_tag(16'h0F0F);
        wait_idle(200, "t5");
        check("t5_first_byte", first_byte, 8'hA5);
        check("t5_tag_count", bus.tag_count, 1);
        check("t5_rd_cnt", rd_cnt, 1);
        check("empty_reads", bad_rd, 0);
        check("stall_hold_all", stall_bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/phase_tag_readout_ctrl.md
Name: phase_tag_readout_ctrl

Overview:
Read-side sequencer for the phase-tag FIFO. It drains 16-bit phase tags from the FIFO read port (RdEn/Q/Empty) in the read clock domain and serializes each tag as two bytes, MSB first, onto a valid/ready byte stream feeding the host link. It inserts a framing sync byte at stream start and periodically thereafter, and it keeps a running count of tags sent.

Parameters:
RD_LATENCY, 1, cycles from fifo_rd_en high to fifo_data valid (1..3)
SYNC_INTERVAL, 64, tags between periodic sync bytes (>=1)
SYNC_BYTE, 8'hA5, framing marker byte value

Ports:
clk  input  1  read-side clock (drives FIFO RdClk)
rst_n  input  1  asynchronous active-low reset
enable  input  1  level; 1 = drain FIFO, 0 = stop at tag boundary
fifo_empty  input  1  FIFO Empty flag
fifo_data  input  16  FIFO Q output
fifo_rd_en  output  1  FIFO RdEn
tx_data  output  8  byte to link
tx_valid  output  1  tx_data valid
tx_ready  input  1  link accepts byte when tx_valid&tx_ready
busy  output  1  high in any state other than IDLE
tag_count  output  16  tags fully sent since reset, wraps

Behaviour:
- Reset (async assert, sync release): state IDLE; fifo_rd_en=0, tx_valid=0, tx_data=0, busy=0, tag_count=0, sync counter=0, first_flag=1.
- States: IDLE, SYNC, RD_REQ, RD_WAIT, SEND_HI, SEND_LO.
- IDLE: if enable & ~fifo_empty -> SYNC when first_flag or sync counter==SYNC_INTERVAL; otherwise -> RD_REQ.
- SYNC: tx_valid=1, tx_data=SYNC_BYTE; on handshake clear first_flag and sync counter, -> RD_REQ.
- RD_REQ: fifo_rd_en=1 for exactly one cycle, -> RD_WAIT. fifo_rd_en is never asserted while fifo_empty=1; fifo_empty is re-checked in RD_REQ; if it is empty there -> IDLE with no read.
- RD_WAIT: wait RD_LATENCY cycles counted from the rd_en cycle; capture fifo_data into the 16-bit holding register on the cycle it is valid, -> SEND_HI.
- SEND_HI: tx_data=tag[15:8], tx_valid=1; on handshake -> SEND_LO.
- SEND_LO: tx_data=tag[7:0]; on handshake tag_count+=1 (wraps 0xFFFF->0), sync counter+=1, then:
  - enable & ~fifo_empty & counter<SYNC_INTERVAL -> RD_REQ (back-to-back; no IDLE cycle)
  - enable & ~fifo_empty & counter==SYNC_INTERVAL -> SYNC
  - otherwise -> IDLE
- tx_data and tx_valid are registered. While tx_valid=1 and tx_ready=0, tx_data holds stable and tx_valid stays high. tx_valid never drops without a handshake, except on reset.
- enable falling: has no effect on a byte or tag in flight. The current tag (both bytes) always completes, then -> IDLE. An enable fall during SYNC still completes the sync byte, then -> RD_REQ only if enable=1, else IDLE.
- enable rising after a stop does not set first_flag. Only reset forces the start sync. Periodic sync counting continues across stops.
- Throughput: at most one fifo_rd_en per 3+RD_LATENCY cycles. With tx_ready held at 1, the tag period is exactly 2+RD_LATENCY+1 cycles.
- fifo_data is ignored outside the capture cycle. FIFO overflow is handled on the write side, not here.
- Reset asserted mid-operation: immediate return to reset values. Any read already issued is lost and not replayed.

Test Plan:
- Reset, enable=1, FIFO holds 0x1234, tx_ready=1 -> bytes A5, 12, 34; one rd_en pulse; tag_count=1; busy falls; no further rd_en while empty.
- FIFO preloaded with 130 tags (SYNC_INTERVAL=64), tx_ready=1 -> A5, then 64 tags, A5, 64 tags, A5, 2 tags; tag_count=130; exactly 130 rd_en pulses.
- tx_ready toggled pseudo-randomly -> tx_data stable whenever valid&~ready; byte order unchanged; no dropped or duplicated bytes.
- Drop enable during SEND_HI of tag 0xBEEF with 5 tags queued -> BE, EF complete, then IDLE; rd_en=0; 4 tags remain; re-enable -> next tag sent with no A5 unless the sync counter is due.
- RD_LATENCY=2 with the FIFO model delaying Q by 2 -> correct values captured; never captures the stale Q.
- Assert rst_n=0 during SEND_LO -> outputs return to reset values immediately; after release and enable, the first byte is A5.
